imem_boot_loader: RTL

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader_if.sv | 36 +++
 rtl/imem_boot_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_boot_loader_if: byte-stream, instruction-memory write and     |
// | hart-control signals of the boot loader.        Revision: 1.0      |
// +--------------------------------------------------------------------+
interface imem_boot_loader_if #(
  parameter int DWIDTH   = 32,
  parameter int MEM_SIZE = 16384
);
  localparam int ADDR_SIZE = $clog2(MEM_SIZE);

  logic                  Boot_Start;
  logic                  Rx_Valid;
  logic [7:0]            Rx_Data;
  logic                  Rx_Ready;
  logic                  Mem_Wr_En;
  logic [ADDR_SIZE-1:0]  Mem_Wr_Addr;
  logic [DWIDTH-1:0]     Mem_Wr_Data;
  logic                  Core_Hold;
  logic                  Load_Done;
  logic                  Load_Error;
  logic [ADDR_SIZE:0]    Word_Count;

  modport master (
    output Boot_Start, Rx_Valid, Rx_Data,
    input  Rx_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data,
    input  Core_Hold, Load_Done, Load_Error, Word_Count
  );

  modport slave (
    input  Boot_Start, Rx_Valid, Rx_Data,
    output Rx_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data,
    output Core_Hold, Load_Done, Load_Error, Word_Count
  );
endinterface
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_boot_loader: loads a length-prefixed, XOR-checksummed byte    |
// | stream into instruction memory, then releases the hart. Rev: 1.0   |
// +--------------------------------------------------------------------+
module imem_boot_loader #(
  parameter int DWIDTH         = 32,
  parameter int MEM_SIZE       = 16384,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  wire logic         Clk_Core,
  input  wire logic         Rst_Core,
  imem_boot_loader_if.slave bus
);
  localparam int ADDR_SIZE = $clog2(MEM_SIZE);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t                state;
  logic                  rx_ready;
  logic                  mem_wr_en;
  logic [ADDR_SIZE-1:0]  mem_wr_addr;
  logic [DWIDTH-1:0]     mem_wr_data;
  logic                  core_hold;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_SIZE:0]    word_count;
  logic [31:0]           n_words;
  logic [23:0]           shift_reg;
  logic [1:0]            byte_cnt;
  logic [7:0]            csum;
  logic [TW-1:0]         idle_cnt;

  logic                  accept;
  logic [31:0]           word_in;
  logic [31:0]           count_next;
  logic                  timed_out;

  // The 4th byte of a group bypasses the shift register so the word is complete on acceptance.
  assign accept     = bus.Rx_Valid & rx_ready;
  assign word_in    = {bus.Rx_Data, shift_reg};
  assign count_next = 32'(word_count) + 32'd1;
  assign timed_out  = (idle_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state       <= IDLE;
      rx_ready    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      core_hold   <= 1'b1;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      word_count  <= '0;
      n_words     <= '0;
      shift_reg   <= '0;
      byte_cnt    <= '0;
      csum        <= '0;
      idle_cnt    <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (bus.Boot_Start) begin
            state      <= HDR;
            rx_ready   <= 1'b1;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            idle_cnt   <= '0;
          end
        end
        HDR, DATA, CSUM: begin
          if (accept) begin
            idle_cnt  <= '0;
            shift_reg <= {bus.Rx_Data, shift_reg[23:8]};
            byte_cnt  <= byte_cnt + 2'd1;
            if (state == HDR) begin
              if (byte_cnt == 2'd3) begin
                n_words <= word_in;
                if (word_in == 32'd0 || word_in > 32'(MEM_SIZE)) begin
                  state      <= ERROR;
                  rx_ready   <= 1'b0;
                  load_error <= 1'b1;
                end else begin
                  state <= DATA;
                end
              end
            end else if (state == DATA) begin
              csum <= csum ^ bus.Rx_Data;
              if (byte_cnt == 2'd3) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= word_count[ADDR_SIZE-1:0];
                mem_wr_data <= DWIDTH'(word_in);
                word_count  <= word_count + 1'b1;
                if (count_next == n_words) begin
                  state <= CSUM;
                end
              end
            end else begin
              rx_ready <= 1'b0;
              if (bus.Rx_Data == csum) begin
                state     <= DONE;
                core_hold <= 1'b0;
                load_done <= 1'b1;
              end else begin
                state      <= ERROR;
                load_error <= 1'b1;
              end
            end
          end else if (timed_out) begin
            state      <= ERROR;
            rx_ready   <= 1'b0;
            load_error <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Rx_Ready    = rx_ready;
  assign bus.Mem_Wr_En   = mem_wr_en;
  assign bus.Mem_Wr_Addr = mem_wr_addr;
  assign bus.Mem_Wr_Data = mem_wr_data;
  assign bus.Core_Hold   = core_hold;
  assign bus.Load_Done   = load_done;
  assign bus.Load_Error  = load_error;
  assign bus.Word_Count  = word_count;
endmodule
`default_nettype wire
